// File: rtl/logic_gate_pipe.sv
// Pipelined, flow-controlled bitwise logic primitive: reduces NUM_IN operand buses with one of eight ops.
// Define LOGIC_GATE_PIPE_STATS_EN to add the result_cnt/stall_cnt statistics ports.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [NUM_IN*WIDTH-1:0] a,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out
`ifdef LOGIC_GATE_PIPE_STATS_EN
  ,
  output logic [31:0]             result_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_PASS = 3'b110,
    OP_NOT  = 3'b111
  } op_e;

  logic [WIDTH-1:0] and_red;
  logic [WIDTH-1:0] or_red;
  logic [WIDTH-1:0] xor_red;
  logic [WIDTH-1:0] result;

  always_comb begin
    and_red = '1;
    or_red  = '0;
    xor_red = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      and_red = and_red & a[i*WIDTH +: WIDTH];
      or_red  = or_red  | a[i*WIDTH +: WIDTH];
      xor_red = xor_red ^ a[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = and_red;
      OP_OR:   result = or_red;
      OP_XOR:  result = xor_red;
      OP_NAND: result = ~and_red;
      OP_NOR:  result = ~or_red;
      OP_XNOR: result = ~xor_red;
      OP_PASS: result = a[WIDTH-1:0];
      OP_NOT:  result = ~a[WIDTH-1:0];
      default: result = '0;
    endcase
  end

  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_load;

  // A stage may load if it or any stage after it is empty, or the output is taken.
  always_comb begin
    logic room;
    room       = out_ready;
    stage_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room          = room | ~stage_valid[k];
      stage_load[k] = room;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      if (stage_load[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) begin
          stage_data[0] <= result;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_load[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_data[k] <= stage_data[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = stage_load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out       = stage_data[STAGES-1];

`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [31:0] result_cnt_r;
  logic [31:0] stall_cnt_r;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_cnt_r <= '0;
      stall_cnt_r  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        result_cnt_r <= result_cnt_r + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign result_cnt = result_cnt_r;
  assign stall_cnt  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe (WIDTH=8, NUM_IN=4, STAGES=3).
// Stats checks are compiled in when LOGIC_GATE_PIPE_STATS_EN is defined.
module tb_logic_gate_pipe;
  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int STAGES = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              op;
  logic [NUM_IN*WIDTH-1:0] a;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out;
`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [31:0]             result_cnt;
  logic [31:0]             stall_cnt;
`endif

  logic_gate_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_GATE_PIPE_STATS_EN
    .result_cnt(result_cnt),
    .stall_cnt (stall_cnt),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int pop_count    = 0;
  int cyc          = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_out   = '0;

  // Per-bit reference: count the ones in each bit column across all operands.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] f, input logic [NUM_IN*WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (v[i*WIDTH + b]) ones++;
      end
      case (f)
        3'd0: r[b] = (ones == NUM_IN);
        3'd1: r[b] = (ones != 0);
        3'd2: r[b] = (ones % 2 == 1);
        3'd3: r[b] = (ones != NUM_IN);
        3'd4: r[b] = (ones == 0);
        3'd5: r[b] = (ones % 2 == 0);
        3'd6: r[b] = v[b];
        default: r[b] = !v[b];
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Called at posedge+1; holds the operand set until the pipeline takes it.
  task automatic applyStimulus(input logic [2:0] f, input logic [NUM_IN*WIDTH-1:0] v);
    bit done;
    done     = 1'b0;
    op       = f;
    a        = v;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: sample mid-cycle, push on accept, pop on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("stall_hold", {56'd0, out}, {56'd0, held_out});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", 64'd0, 64'd1);
        end else begin
          checkOutput("result", {56'd0, out}, {56'd0, exp_q.pop_front()});
        end
        pop_count++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_op(op, a));
      stall_prev = out_valid && !out_ready;
      held_out   = out;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NUM_IN*WIDTH-1:0] vec;
    logic [2:0]              bp_op [5];
    logic [NUM_IN*WIDTH-1:0] bp_a  [5];
    int idx, n, c0, pc0;
    bit got;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_out", {56'd0, out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Truth sweep: two words per op enumerate all 16 column patterns of 4 operands.
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int w = 0; w < 2; w++) begin
        vec = '0;
        for (int i = 0; i < NUM_IN; i++)
          for (int j = 0; j < WIDTH; j++)
            vec[i*WIDTH + j] = 1'(((w*8 + j) >> i) & 1);
        applyStimulus(3'(f), vec);
      end
    end
    repeat (STAGES + 2) @(posedge clk);
    #1;
    checkOutput("truth_drained", 64'(exp_q.size()), 64'd0);

    // Multi-input AND/OR/XOR with latency measurement.
    for (int f = 0; f < 3; f++) begin
      applyStimulus(3'(f), {8'hFF, 8'hAA, 8'hCC, 8'hF0});
      n = 1; got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (out_valid) got = 1'b1;
        else begin
          @(posedge clk);
          n++;
        end
      end
      checkOutput("latency", 64'(n), 64'(STAGES));
      @(posedge clk);
      #1;
    end
    repeat (STAGES + 2) @(posedge clk);
    #1;

    // Back-pressure: five offered values against a stalled output.
    for (int i = 0; i < 5; i++) begin
      bp_op[i] = 3'($urandom_range(0, 7));
      bp_a[i]  = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      op = bp_op[idx < 5 ? idx : 4];
      a  = bp_a[idx < 5 ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepts", 64'(idx), 64'(STAGES));
    checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp_out_first", {56'd0, out}, {56'd0, ref_op(bp_op[0], bp_a[0])});
    out_ready = 1'b1;
    for (int i = idx; i < 5; i++) applyStimulus(bp_op[i], bp_a[i]);
    repeat (STAGES + 2) @(posedge clk);
    #1;
    checkOutput("bp_drained", 64'(exp_q.size()), 64'd0);

    // Full throughput: 100 back-to-back random inputs.
    c0 = cyc; pc0 = pop_count;
    for (int i = 0; i < 100; i++) applyStimulus(3'($urandom_range(0, 7)), $urandom);
    checkOutput("tp_accept_cycles", 64'(cyc - c0), 64'd100);
    repeat (STAGES) @(posedge clk);
    #1;
    checkOutput("tp_outputs", 64'(pop_count - pc0), 64'd100);

    // Reset mid-stream with a full, stalled pipeline.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) applyStimulus(3'(i), $urandom);
    checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_out", {56'd0, out}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    pc0 = pop_count;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrst_no_stale", 64'(pop_count - pc0), 64'd0);

`ifdef LOGIC_GATE_PIPE_STATS_EN
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) applyStimulus(3'd1, $urandom);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = STAGES; i < 10; i++) applyStimulus(3'd2, $urandom);
    repeat (STAGES + 2) @(posedge clk);
    #1;
    checkOutput("result_cnt", 64'(result_cnt), 64'd10);
    checkOutput("stall_cnt", 64'(stall_cnt), 64'd4);
    force dut.result_cnt_r = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.result_cnt_r;
    @(posedge clk);
    #1;
    applyStimulus(3'd0, $urandom);
    repeat (STAGES + 1) @(posedge clk);
    #1;
    checkOutput("result_cnt_wrap", 64'(result_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
